alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the datapath single-cycle ALU.
- Keeps the existing ALUCtrl encodings for the logic, add/sub, set-less-than and shift operations, generalised to WIDTH bits.
- Adds arithmetic shift, unsigned set-less-than, and iterative multiply/divide, with results held in HI/LO.
- Sits in the EX stage of a multi-cycle core; the control FSM stalls on in_ready.

Parameters:
- WIDTH, 32: operand and result width; must be a power of two, at least 8.
- SHW, $clog2(WIDTH): shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operation request, sampled when in_ready=1.
- in_ready  output  1  unit idle, can accept an op.
- in0  input  WIDTH  operand A (rs).
- in1  input  WIDTH  operand B (rt / immediate).
- ALUCtrl  input  4  operation select.
- shamt  input  SHW  shift amount.
- out_valid  output  1  one-cycle pulse, result fields valid.
- ALUResult  output  WIDTH  registered result.
- Zero  output  1  registered, ALUResult==0.
- HI  output  WIDTH  product high half / remainder.
- LO  output  WIDTH  product low half / quotient.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, ALUResult=0, Zero=1, HI=0, LO=0.
  - Any in-flight op is abandoned with no out_valid.
- Accept: an op is accepted on any edge with in_valid=1 and in_ready=1. Operands, ALUCtrl and shamt are captured. Inputs are don't-care at all other times.
- Encodings and latency (latency = edges from accept to the out_valid cycle):
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (in0-in1).
  - 0111 SLT signed: result {0,...,lt}. lt uses the sign of in0 when the signs differ, otherwise the sign of the difference.
  - 0011 SLTU unsigned compare.
  - 1000 SLL (in1<<shamt), 1001 SRL (logical), 1010 SRA (arithmetic, of in1).
  - These single-cycle ops have latency 1. in_ready stays 1, so back-to-back accepts give one result per cycle.
  - ADD/SUB wrap modulo 2^WIDTH; there is no overflow flag.
  - 1100 MULTU: unsigned shift-add, one partial product per cycle. {HI,LO}=in0*in1. ALUResult=LO. Latency WIDTH+1.
  - 1101 DIVU: unsigned restoring division, one quotient bit per cycle. LO=in0/in1, HI=in0%in1. ALUResult=LO. Latency WIDTH+1.
  - Divide by zero produces no exception: LO=all ones, HI=in0. This is the natural restoring result and is required.
  - Any other code gives ALUResult=0, Zero=1, latency 1, with HI/LO unchanged.
- HI/LO:
  - Written only on completion of MULTU/DIVU.
  - Held otherwise, including across single-cycle ops.
  - Not updated during iteration; they change on the same edge that raises out_valid.
- States:
  - IDLE: in_ready=1. Accepting MULTU goes to MUL and DIVU goes to DIV; any other accept stays in IDLE.
  - MUL/DIV: in_ready=0. The iteration counter counts 0..WIDTH-1. At WIDTH-1 the state goes to FIN.
  - FIN: writes HI/LO/ALUResult/Zero, pulses out_valid, sets in_ready=1, and returns to IDLE.
  - in_valid during MUL/DIV is ignored; the requester must hold it.
- out_valid:
  - Exactly one cycle per accepted op; no backpressure.
  - ALUResult and Zero hold their value until the next completion.
- Width rules:
  - The internal multiplier accumulator is 2*WIDTH bits; the divider partial remainder is WIDTH+1 bits.
  - Shift amount is taken modulo WIDTH by construction, since shamt is SHW bits.

Test Plan:
- Reset: assert rst_n=0 mid-MULTU (cycle 10), release -> in_ready=1, out_valid never pulses, HI=LO=0, ALUResult=0, Zero=1.
- Back-to-back single-cycle ops: ADD 5+7, SUB 3-3, SLT 0xFFFFFFFF vs 1, SLTU 0xFFFFFFFF vs 1, on consecutive cycles.
  - Required: results 12 (Zero=0), 0 (Zero=1), 1, 0 on consecutive cycles, one out_valid each.
- Shifts: in1=0x80000001, shamt=4.
  - Required: SLL=0x00000010, SRL=0x08000000, SRA=0xF8000000.
- MULTU 0xFFFFFFFF*0xFFFFFFFF:
  - in_ready low for 32 cycles; out_valid exactly 33 edges after accept.
  - HI=0xFFFFFFFE, LO=0x00000001, ALUResult=1.
  - in_valid held high during busy is not re-accepted.
- DIVU 100/7 -> LO=14, HI=2. DIVU 0x1234/0 -> LO=0xFFFFFFFF, HI=0x00001234, latency 33.
- HI/LO retention: after MULTU, issue OR 0xF0|0x0F.
  - Required: ALUResult=0xFF, HI/LO unchanged.
  - Undefined code 1111 -> ALUResult=0, Zero=1.
  - Repeat the suite with WIDTH=8 and latency 9.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with single-cycle ops and iterative MULTU/DIVU into HI/LO
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [3:0]       ALUCtrl,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               ov_q, ov_d;

  logic [WIDTH-1:0]   alu_res, sum_ab, diff_ab;
  logic               slt_bit;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_trial;
  logic               div_ge, last;
  logic [WIDTH-1:0]   quo_next, rem_next;

  always_comb begin
    sum_ab  = in0 + in1;
    diff_ab = in0 - in1;
    slt_bit = (in0[WIDTH-1] != in1[WIDTH-1]) ? in0[WIDTH-1] : diff_ab[WIDTH-1];
    alu_res = '0;
    case (ALUCtrl)
      OP_AND:  alu_res = in0 & in1;
      OP_OR:   alu_res = in0 | in1;
      OP_ADD:  alu_res = sum_ab;
      OP_SUB:  alu_res = diff_ab;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in0 < in1)};
      OP_SLL:  alu_res = in1 << shamt;
      OP_SRL:  alu_res = in1 >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(in1) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Multiplier: multiplicand in dvs_q, multiplier shifts out of acc_q low half.
  // Divider: dividend shifts out of acc_q low half while quotient bits shift in.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    res_d   = res_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ov_d    = 1'b0;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, dvs_q};
    div_ge    = ~div_trial[WIDTH];
    quo_next  = {acc_q[WIDTH-2:0], div_ge};
    rem_next  = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    last      = (cnt_q == SHW'(WIDTH-1));

    case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (in_valid) begin
          case (ALUCtrl)
            OP_MULTU: begin
              acc_d   = {{WIDTH{1'b0}}, in1};
              dvs_d   = in0;
              cnt_d   = '0;
              state_d = S_MUL;
            end
            OP_DIVU: begin
              acc_d   = {{WIDTH{1'b0}}, in0};
              dvs_d   = in1;
              rem_d   = '0;
              cnt_d   = '0;
              state_d = S_DIV;
            end
            default: begin
              res_d  = alu_res;
              zero_d = (alu_res == '0);
              ov_d   = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + SHW'(1);
        if (last) begin
          hi_d    = mul_next[2*WIDTH-1:WIDTH];
          lo_d    = mul_next[WIDTH-1:0];
          res_d   = mul_next[WIDTH-1:0];
          zero_d  = (mul_next[WIDTH-1:0] == '0);
          ov_d    = 1'b1;
          state_d = S_FIN;
        end
      end
      S_DIV: begin
        acc_d = {acc_q[2*WIDTH-1:WIDTH], quo_next};
        rem_d = rem_next;
        cnt_d = cnt_q + SHW'(1);
        if (last) begin
          hi_d    = rem_next;
          lo_d    = quo_next;
          res_d   = quo_next;
          zero_d  = (quo_next == '0);
          ov_d    = 1'b1;
          state_d = S_FIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      hi_q    <= '0;
      lo_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_FIN);
  assign out_valid = ov_q;
  assign ALUResult = res_q;
  assign Zero      = zero_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH=32 and WIDTH=8
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, w8;
  logic [31:0] in0, in1;
  logic [3:0]  ctrl;
  logic [4:0]  shamt;

  logic        rdy32, ov32, z32;
  logic [31:0] res32, hi32, lo32;
  logic        rdy8, ov8, z8;
  logic [7:0]  res8, hi8, lo8;

  logic        rdy, ov, zero;
  logic [31:0] res, hi, lo;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~w8), .in_ready(rdy32),
    .in0(in0), .in1(in1), .ALUCtrl(ctrl), .shamt(shamt),
    .out_valid(ov32), .ALUResult(res32), .Zero(z32), .HI(hi32), .LO(lo32)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & w8), .in_ready(rdy8),
    .in0(in0[7:0]), .in1(in1[7:0]), .ALUCtrl(ctrl), .shamt(shamt[2:0]),
    .out_valid(ov8), .ALUResult(res8), .Zero(z8), .HI(hi8), .LO(lo8)
  );

  assign rdy  = w8 ? rdy8 : rdy32;
  assign ov   = w8 ? ov8  : ov32;
  assign zero = w8 ? z8   : z32;
  assign res  = w8 ? {24'h0, res8} : res32;
  assign hi   = w8 ? {24'h0, hi8}  : hi32;
  assign lo   = w8 ? {24'h0, lo8}  : lo32;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL w%0d %s: got %h expected %h", w8 ? 8 : 32, tag, got, exp);
  endtask

  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input bit hold, output int lat, output int busy);
    ctrl = c; in0 = a; in1 = b; shamt = sh; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1; busy = 0;
    if (!hold) in_valid = 1'b0;
    while (!ov && lat < 100) begin
      if (!rdy) busy++;
      else in_valid = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic op1(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh, input logic [31:0] eres, input logic ez, input string tag);
    int lat, busy;
    run_op(c, a, b, sh, 1'b0, lat, busy);
    check({tag, "_ov"}, 32'(ov), 32'd1);
    check({tag, "_lat"}, lat, 1);
    check({tag, "_res"}, res, eres);
    check({tag, "_zero"}, 32'(zero), 32'(ez));
  endtask

  task automatic b2b(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eres, input logic ez, input string tag);
    ctrl = c; in0 = a; in1 = b; shamt = '0;
    @(posedge clk); #1;
    check({tag, "_ov"}, 32'(ov), 32'd1);
    check({tag, "_res"}, res, eres);
    check({tag, "_zero"}, 32'(zero), 32'(ez));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rdy"}, 32'(rdy), 32'd1);
    check({tag, "_ov"}, 32'(ov), 32'd0);
    check({tag, "_res"}, res, 32'd0);
    check({tag, "_zero"}, 32'(zero), 32'd1);
    check({tag, "_hi"}, hi, 32'd0);
    check({tag, "_lo"}, lo, 32'd0);
  endtask

  task automatic run_suite(input int W);
    logic [31:0] m, sh_in, dz;
    int lat, busy, seen;
    m     = (W == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    sh_in = (W == 32) ? 32'h8000_0001 : 32'h0000_0081;
    dz    = (W == 32) ? 32'h0000_1234 : 32'h0000_0012;

    in_valid = 1'b1;
    b2b(4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, "b2b_add");
    b2b(4'b0110, 32'd3, 32'd3, 32'd0, 1'b1, "b2b_sub");
    b2b(4'b0111, m, 32'd1, 32'd1, 1'b0, "b2b_slt");
    b2b(4'b0011, m, 32'd1, 32'd0, 1'b1, "b2b_sltu");
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_idle_ov", 32'(ov), 32'd0);

    op1(4'b1000, 32'd0, sh_in, 5'd4, 32'h10, 1'b0, "sll");
    op1(4'b1001, 32'd0, sh_in, 5'd4, (W == 32) ? 32'h0800_0000 : 32'h08, 1'b0, "srl");
    op1(4'b1010, 32'd0, sh_in, 5'd4, (W == 32) ? 32'hF800_0000 : 32'hF8, 1'b0, "sra");
    op1(4'b0110, 32'd3, 32'd5, 5'd0, m - 32'd1, 1'b0, "sub_wrap");

    run_op(4'b1100, m, m, 5'd0, 1'b1, lat, busy);
    check("mul_ov", 32'(ov), 32'd1);
    check("mul_lat", lat, W + 1);
    check("mul_busy", busy, W);
    check("mul_hi", hi, m - 32'd1);
    check("mul_lo", lo, 32'd1);
    check("mul_res", res, 32'd1);
    @(posedge clk); #1;
    check("mul_reaccept_ov", 32'(ov), 32'd0);
    check("mul_reaccept_rdy", 32'(rdy), 32'd1);

    op1(4'b0001, 32'hF0, 32'h0F, 5'd0, 32'hFF, 1'b0, "or");
    check("or_hi_held", hi, m - 32'd1);
    check("or_lo_held", lo, 32'd1);
    op1(4'b1111, 32'd5, 32'd5, 5'd0, 32'd0, 1'b1, "undef");
    check("undef_hi_held", hi, m - 32'd1);
    check("undef_lo_held", lo, 32'd1);

    run_op(4'b1101, 32'd100, 32'd7, 5'd0, 1'b0, lat, busy);
    check("div_ov", 32'(ov), 32'd1);
    check("div_lat", lat, W + 1);
    check("div_lo", lo, 32'd14);
    check("div_hi", hi, 32'd2);
    check("div_res", res, 32'd14);
    check("div_zero", 32'(zero), 32'd0);

    run_op(4'b1101, dz, 32'd0, 5'd0, 1'b0, lat, busy);
    check("div0_ov", 32'(ov), 32'd1);
    check("div0_lat", lat, W + 1);
    check("div0_lo", lo, m);
    check("div0_hi", hi, dz);

    ctrl = 4'b1100; in0 = m; in1 = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_state("midrst");
    seen = 0;
    repeat (2 * W + 10) begin
      @(posedge clk); #1;
      if (ov) seen = 1;
    end
    check("midrst_no_ov", seen, 0);
    check("midrst_hi_after", hi, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; w8 = 1'b0;
    in0 = '0; in1 = '0; ctrl = '0; shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    w8 = 1'b1;
    #1;
    check_reset_state("rst");
    w8 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_suite(32);
    w8 = 1'b1;
    #1;
    run_suite(8);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
